shift_arbiter: RTL
==================

# shift_arbiter

Shares one 32-bit barrel shifter between two requesters: port 0 is the ALU shift path and port 1 is the load/store byte-alignment path. Arbitration is round-robin. Each requester uses a valid/ready handshake. The result is registered into a single-entry output stage, and the consumer drains that stage with its own valid/ready handshake. The block sits between the execute-stage issue logic and the writeback mux.

## Interface
Parameters:
- PRIO_INIT, default 0: requester that wins the first tie after reset (0 or 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- r0_valid  in  1  requester 0 has a shift request.
- r0_ready  out  1  requester 0 request is accepted this cycle.
- r0_a  in  32  requester 0 operand to shift.
- r0_b  in  32  requester 0 shift amount; only bits [4:0] are used.
- r0_op  in  2  requester 0 operation: 00 SLL, 01 SRL, 10 SRA, 11 pass.
- r0_tag  in  4  requester 0 tag, returned unchanged with the result.
- r1_valid, r1_ready, r1_a, r1_b, r1_op, r1_tag: same as the r0 ports, for requester 1.
- res_valid  out  1  output stage holds a result.
- res_ready  in  1  consumer takes the result this cycle.
- res_data  out  32  shift result.
- res_src  out  1  requester that produced the result (0 or 1).
- res_tag  out  4  tag of that request.
- busy  out  1  equals res_valid; kept for pipeline stall logic.

## Operation
- slot_free = !res_valid | res_ready. A request can be accepted only when slot_free is 1.
- Grant rules, when slot_free = 1:
  - Only r0_valid asserted: grant requester 0.
  - Only r1_valid asserted: grant requester 1.
  - Both asserted: grant the requester that did not win the last grant (round-robin pointer).
- rX_ready is combinational: grant to X AND slot_free. rX_ready may be high while rX_valid is low only if the grant logic selects X, which it never does. In practice rX_ready implies rX_valid.
- On an accepted request (rX_valid & rX_ready):
  - res_data <= shift(rX_a, rX_b[4:0], rX_op).
  - res_src <= X, res_tag <= rX_tag, res_valid <= 1.
  - Pointer records X as the last winner.
- Shift semantics:
  - SLL fills with zeros from the bottom.
  - SRL fills with zeros from the top.
  - SRA fills with the original bit 31 of a.
  - Shift amount 0 returns a unchanged.
  - op 11 returns a unchanged and ignores b. The block never drives the shifter with code 11.
- Drain only (res_valid & res_ready, no new accept): res_valid <= 0. res_data, res_src and res_tag keep their last values.
- Drain and accept in the same cycle: the new result replaces the old one, and res_valid stays 1.
- Output stability: while res_valid = 1 and res_ready = 0, res_data, res_src and res_tag must not change.
- Requester inputs need not stay stable before they are accepted. The block samples them only in the accept cycle.
- The pointer updates only on an accept. Idle cycles and stalled cycles do not move it.

## Timing
- Latency: a request accepted in cycle N is on res_* with res_valid = 1 in cycle N+1.
- Throughput: one result per cycle while res_ready is held 1.
- Combinational paths:
  - res_ready -> rX_ready is combinational.
  - rX_valid -> rY_ready is combinational.
  - No path from rX_a, rX_b or rX_op to any output is combinational.
- Reset values (asynchronous on assertion, released on the clock):
  - res_valid = 0, busy = 0.
  - res_data = 0, res_src = 0, res_tag = 0.
  - Round-robin pointer set so that PRIO_INIT wins the first tie.
- Reset while a result is held or stalled discards that result with no handshake to either side.
- After rst_n deasserts, the first accept can occur in the first clock edge where rst_n is high.

## Test plan
- Reset with PRIO_INIT = 0; both requesters valid:
  - r0: a = 0x0000_00F0, b = 4, op SLL, tag 3.
  - r1: a = 0x8000_0000, b = 31, op SRA, tag 9.
  - Required: cycle 1 res_data = 0x0000_0F00, src 0, tag 3. Cycle 2 res_data = 0xFFFF_FFFF, src 1, tag 9.
- Hold res_ready = 0 for 5 cycles with a result 0x1234_5678 held and r1 valid:
  - res_* stays 0x1234_5678 throughout, r1_ready = 0, busy = 1.
  - res_ready rises -> r1 is accepted in that same cycle.
- Only r0 valid for 4 consecutive cycles, res_ready = 1:
  - 4 accepts back to back, res_valid high continuously from cycle 1.
  - r0 keeps winning with no bubbles, because r1 never requests.
- Operation sweep on requester 1:
  - SRL a = 0x8000_0000, b = 0x0000_0021 (amount 1) -> 0x4000_0000.
  - op 11, a = 0xDEAD_BEEF -> 0xDEAD_BEEF.
  - SLL with amount 0 -> a unchanged.
- Assert rst_n = 0 mid-stall while res_valid = 1:
  - res_valid drops to 0 immediately, without waiting for a clock.
  - After release, a simultaneous request is granted to PRIO_INIT.

Source files
------------

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter
// Purpose  : Round-robin share of one 32-bit barrel shifter between the ALU
//            shift path (r0) and the load/store alignment path (r1).
// Revision : 1.0
// ============================================================================
module shift_arbiter #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [1:0]  r0_op,
  input  logic [3:0]  r0_tag,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic [1:0]  r1_op,
  input  logic [3:0]  r1_tag,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_src,
  output logic [3:0]  res_tag,
  output logic        busy
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q,  res_data_d;
  logic        res_src_q,   res_src_d;
  logic [3:0]  res_tag_q,   res_tag_d;
  logic        last_q,      last_d;

  logic        slot_free;
  logic        pick0, pick1;
  logic        accept;
  logic [31:0] sel_a;
  logic [4:0]  sel_amt;
  logic [1:0]  sel_op;
  logic [3:0]  sel_tag;
  logic        shift_left;
  logic        fill;
  logic [31:0] a_rev;
  logic [31:0] stage [6];
  logic [31:0] shift_out;
  logic [31:0] result;

  // last_q holds the previous winner; on a tie the other requester goes.
  always_comb begin
    slot_free = !res_valid_q | res_ready;
    pick1     = r1_valid & (!r0_valid | !last_q);
    pick0     = r0_valid & !pick1;
    r0_ready  = pick0 & slot_free;
    r1_ready  = pick1 & slot_free;
    accept    = r0_ready | r1_ready;
  end

  always_comb begin
    sel_a   = pick1 ? r1_a       : r0_a;
    sel_amt = pick1 ? r1_b[4:0]  : r0_b[4:0];
    sel_op  = pick1 ? r1_op      : r0_op;
    sel_tag = pick1 ? r1_tag     : r0_tag;
  end

  // Left shifts reuse the right-shift network on a bit-reversed operand.
  always_comb begin
    shift_left = (sel_op == OP_SLL);
    fill       = (sel_op == OP_SRA) & sel_a[31];
    for (int i = 0; i < 32; i++) begin
      a_rev[i] = sel_a[31-i];
    end
  end

  assign stage[0] = shift_left ? a_rev : sel_a;

  for (genvar k = 0; k < 5; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign stage[k+1] = sel_amt[k] ? {{SH{fill}}, stage[k][31:SH]} : stage[k];
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      shift_out[i] = shift_left ? stage[5][31-i] : stage[5][i];
    end
    result = (sel_op == OP_PASS) ? sel_a : shift_out;
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_src_d   = res_src_q;
    res_tag_d   = res_tag_q;
    last_d      = last_q;
    if (accept) begin
      res_valid_d = 1'b1;
      res_data_d  = result;
      res_src_d   = pick1;
      res_tag_d   = sel_tag;
      last_d      = pick1;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= 32'h0;
      res_src_q   <= 1'b0;
      res_tag_q   <= 4'h0;
      last_q      <= ~PRIO_INIT;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_src_q   <= res_src_d;
      res_tag_q   <= res_tag_d;
      last_q      <= last_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_src   = res_src_q;
  assign res_tag   = res_tag_q;
  assign busy      = res_valid_q;

endmodule
`default_nettype wire
